// File: rtl/usb_packet_buffer.sv
// rtl/usb_packet_buffer.sv - shared RX/TX byte FIFO between the USB engines and the AHB slave
//
// Ports:
//   clk, n_rst                    clock, synchronous active-high reset
//   flush, clear                  empty the buffer and drop uncommitted bytes
//   store_rx_packet_data, rx_packet_data, rx_commit, rx_abort
//                                 USB RX byte push with packet commit/abort
//   get_rx_data, rx_size, rx_data AHB pop of 1/2/4 bytes, registered result
//   store_tx_data, tx_size, tx_data
//                                 AHB push of 1/2/4 bytes, committed at once
//   get_tx_packet_data, tx_packet_data
//                                 USB TX byte pop, show-ahead head byte
//   buffer_occupancy              committed byte count
//   overflow, underflow           one-cycle pulses for rejected push/pop
module usb_packet_buffer #(
  parameter int DEPTH = 64,
  parameter int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             clear,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             rx_commit,
  input  logic             rx_abort,
  input  logic             get_rx_data,
  input  logic [1:0]       rx_size,
  output logic [31:0]      rx_data,
  input  logic             store_tx_data,
  input  logic [1:0]       tx_size,
  input  logic [31:0]      tx_data,
  input  logic             get_tx_packet_data,
  output logic [7:0]       tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [OCC_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0] cptr_q, cptr_d;
  logic [OCC_W-1:0] wptr_q, wptr_d;
  logic [31:0]      rx_data_q, rx_data_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [OCC_W-1:0] occ, used, space;
  logic [OCC_W-1:0] tx_n, rx_n;

  logic [3:0]       wr_en;
  logic [AW-1:0]    wr_idx  [4];
  logic [7:0]       wr_byte [4];

  // Size code 3 is treated as a word access.
  function automatic logic [OCC_W-1:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    size_bytes = OCC_W'(1);
      2'd1:    size_bytes = OCC_W'(2);
      default: size_bytes = OCC_W'(4);
    endcase
  endfunction

  assign occ   = cptr_q - rptr_q;
  assign used  = wptr_q - rptr_q;
  assign space = OCC_W'(DEPTH) - used;
  assign tx_n  = size_bytes(tx_size);
  assign rx_n  = size_bytes(rx_size);

  always_comb begin
    rptr_d      = rptr_q;
    cptr_d      = cptr_q;
    wptr_d      = wptr_q;
    rx_data_d   = rx_data_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    wr_en       = '0;
    for (int k = 0; k < 4; k++) begin
      wr_idx[k]  = wptr_q[AW-1:0] + AW'(k);
      wr_byte[k] = tx_data[8*k +: 8];
    end

    if (flush || clear) begin
      rptr_d = '0;
      cptr_d = '0;
      wptr_d = '0;
    end else begin
      // Push side: the RX engine has priority over the AHB.
      if (store_rx_packet_data) begin
        if (store_tx_data) overflow_d = 1'b1;
        // A store in the same cycle as an abort belongs to the bad packet.
        if (!rx_abort) begin
          if (space != '0) begin
            wr_en[0]   = 1'b1;
            wr_byte[0] = rx_packet_data;
            wptr_d     = wptr_q + OCC_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
      end else if (store_tx_data) begin
        if (space >= tx_n) begin
          for (int k = 0; k < 4; k++) wr_en[k] = (OCC_W'(k) < tx_n);
          wptr_d = wptr_q + tx_n;
          cptr_d = wptr_q + tx_n;
        end else begin
          overflow_d = 1'b1;
        end
      end

      // Commit sees the post-cycle write pointer so a same-cycle byte is included.
      if (rx_abort)       wptr_d = cptr_d;
      else if (rx_commit) cptr_d = wptr_d;

      // Pop side: only committed bytes are visible; AHB has priority over USB TX.
      if (get_rx_data) begin
        if (get_tx_packet_data) underflow_d = 1'b1;
        if (occ >= rx_n) begin
          rx_data_d = '0;
          for (int k = 0; k < 4; k++) begin
            if (OCC_W'(k) < rx_n) rx_data_d[8*k +: 8] = mem_q[rptr_q[AW-1:0] + AW'(k)];
          end
          rptr_d = rptr_q + rx_n;
        end else begin
          underflow_d = 1'b1;
        end
      end else if (get_tx_packet_data) begin
        if (occ != '0) rptr_d = rptr_q + OCC_W'(1);
        else           underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      rptr_q      <= '0;
      cptr_q      <= '0;
      wptr_q      <= '0;
      rx_data_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rptr_q      <= rptr_d;
      cptr_q      <= cptr_d;
      wptr_q      <= wptr_d;
      rx_data_q   <= rx_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset; writes are simply suppressed while reset is held.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!n_rst && wr_en[k]) mem_q[wr_idx[k]] <= wr_byte[k];
    end
  end

  assign rx_data          = rx_data_q;
  assign tx_packet_data   = mem_q[rptr_q[AW-1:0]];
  assign buffer_occupancy = occ;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;

endmodule
